// File: rtl/cla_share_ctrl_if.sv
// Bundle between the two execute-stage requesters, the shared-adder controller
// and the external 32-bit carry-lookahead adder.
interface cla_share_ctrl_if;
  logic        req0;
  logic        req1;
  logic        wide0;
  logic        wide1;
  logic        sub0;
  logic        sub1;
  logic [63:0] a0;
  logic [63:0] b0;
  logic [63:0] a1;
  logic [63:0] b1;
  logic        done0;
  logic        done1;
  logic [63:0] result;
  logic        cout;
  logic        ovf;
  logic        busy;
  logic [31:0] cla_a;
  logic [31:0] cla_b;
  logic        cla_c0;
  logic [31:0] cla_sum;
  logic        cla_c32;

  modport slave (
    input  req0, req1, wide0, wide1, sub0, sub1, a0, b0, a1, b1,
    input  cla_sum, cla_c32,
    output done0, done1, result, cout, ovf, busy,
    output cla_a, cla_b, cla_c0
  );

  modport master (
    output req0, req1, wide0, wide1, sub0, sub1, a0, b0, a1, b1,
    output cla_sum, cla_c32,
    input  done0, done1, result, cout, ovf, busy,
    input  cla_a, cla_b, cla_c0
  );
endinterface

// File: rtl/cla_share_ctrl.sv
// Round-robin sequencer that time-shares one external 32-bit CLA adder between
// two requesters, running one pass for 32-bit ops and two chained passes for 64-bit ops.
//
//   state | meaning
//   IDLE  | adder inputs forced to 0, arbitrating eligible requests
//   LO    | low word on the adder (or the only word of a 32-bit op)
//   HI    | high word on the adder, carry-in from the low pass
module cla_share_ctrl (
  input  logic         clock,
  input  logic         reset_n,
  cla_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t      state;
  state_t      state_nx;

  logic        owner;
  logic        wide_l;
  logic        sub_l;
  logic        carry_l;
  logic        last_gnt;
  logic [63:0] a_l;
  logic [63:0] bx_l;

  logic [63:0] result_r;
  logic        cout_r;
  logic        ovf_r;
  logic        done0_r;
  logic        done1_r;

  logic        elig0;
  logic        elig1;
  logic        grant;
  logic        gnt_id;
  logic        gnt_wide;
  logic        gnt_sub;
  logic [63:0] gnt_a;
  logic [63:0] gnt_b;
  logic        finish;
  logic [31:0] seg_a;
  logic [31:0] seg_b;
  logic        seg_c;
  logic        seg_ovf;

  // A requester is masked during its own done cycle so it cannot be regranted
  // on a request it has not yet had a chance to drop.
  assign elig0 = bus.req0 & ~done0_r;
  assign elig1 = bus.req1 & ~done1_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gnt_id   = 1'b0;
    finish   = 1'b0;
    seg_a    = 32'd0;
    seg_b    = 32'd0;
    seg_c    = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          grant    = 1'b1;
          gnt_id   = (elig0 & elig1) ? ~last_gnt : elig1;
          state_nx = LO;
        end
      end
      LO: begin
        seg_a    = a_l[31:0];
        seg_b    = bx_l[31:0];
        seg_c    = sub_l;
        finish   = ~wide_l;
        state_nx = wide_l ? HI : IDLE;
      end
      HI: begin
        seg_a    = a_l[63:32];
        seg_b    = bx_l[63:32];
        seg_c    = carry_l;
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign gnt_wide = gnt_id ? bus.wide1 : bus.wide0;
  assign gnt_sub  = gnt_id ? bus.sub1  : bus.sub0;
  assign gnt_a    = gnt_id ? bus.a1    : bus.a0;
  assign gnt_b    = gnt_id ? bus.b1    : bus.b0;

  // Overflow judged on the inverted b actually presented to the adder.
  assign seg_ovf = (seg_a[31] == seg_b[31]) & (bus.cla_sum[31] != seg_a[31]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= 1'b0;
      wide_l   <= 1'b0;
      sub_l    <= 1'b0;
      carry_l  <= 1'b0;
      last_gnt <= 1'b1;
      a_l      <= 64'd0;
      bx_l     <= 64'd0;
      result_r <= 64'd0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
    end else begin
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      if (grant) begin
        owner    <= gnt_id;
        last_gnt <= gnt_id;
        wide_l   <= gnt_wide;
        sub_l    <= gnt_sub;
        a_l      <= gnt_a;
        bx_l     <= gnt_sub ? ~gnt_b : gnt_b;
      end
      if (state == LO) begin
        result_r[31:0] <= bus.cla_sum;
        carry_l        <= bus.cla_c32;
        if (!wide_l) result_r[63:32] <= 32'd0;
      end
      if (state == HI) result_r[63:32] <= bus.cla_sum;
      if (finish) begin
        cout_r  <= bus.cla_c32;
        ovf_r   <= seg_ovf;
        done0_r <= ~owner;
        done1_r <= owner;
      end
    end
  end

  assign bus.done0  = done0_r;
  assign bus.done1  = done1_r;
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  assign bus.ovf    = ovf_r;
  assign bus.busy   = (state != IDLE);
  assign bus.cla_a  = seg_a;
  assign bus.cla_b  = seg_b;
  assign bus.cla_c0 = seg_c;

endmodule

// File: tb/tb_cla_share_ctrl.sv
// Randomized bench for cla_share_ctrl: behavioural adder, arithmetic reference
// model for results/flags, and round-robin order check under contention.
module tb_cla_share_ctrl;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   done_order[$];
  bit   mon_en;

  cla_share_ctrl_if bus ();

  cla_share_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External adder
  assign {bus.cla_c32, bus.cla_sum} = {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + {32'd0, bus.cla_c0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, result} from the arithmetic meaning of the op.
  function automatic logic [65:0] ref_op(input logic wide, input logic sub,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [32:0] t;
    logic [63:0] r;
    logic        co;
    logic        ov;
    if (wide) begin
      s  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      r  = s[63:0];
      co = sub ? ~s[64] : s[64];
      ov = sub ? ((a[63] != b[63]) && (r[63] != a[63]))
               : ((a[63] == b[63]) && (r[63] != a[63]));
    end else begin
      t  = sub ? ({1'b0, a[31:0]} - {1'b0, b[31:0]}) : ({1'b0, a[31:0]} + {1'b0, b[31:0]});
      r  = {32'd0, t[31:0]};
      co = sub ? ~t[32] : t[32];
      ov = sub ? ((a[31] != b[31]) && (r[31] != a[31]))
               : ((a[31] == b[31]) && (r[31] != a[31]));
    end
    return {ov, co, r};
  endfunction

  function automatic logic done_of(input int id);
    return (id == 0) ? bus.done0 : bus.done1;
  endfunction

  task automatic drive(input int id, input logic req, input logic wide, input logic sub,
                       input logic [63:0] a, input logic [63:0] b);
    if (id == 0) begin
      bus.req0 = req; bus.wide0 = wide; bus.sub0 = sub; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = req; bus.wide1 = wide; bus.sub1 = sub; bus.a1 = a; bus.b1 = b;
    end
  endtask

  function automatic logic [63:0] rnd_opnd();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h7FFF_FFFF_7FFF_FFFF;
      3:       v = 64'h8000_0000_8000_0000;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Single op from idle, no contention; checks latency, flags, done width and hold.
  task automatic run_op(input int id, input logic wide, input logic sub,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output logic co, output logic ov);
    logic [65:0] e;
    int          cyc;
    bit          got;
    e = ref_op(wide, sub, a, b);
    @(negedge clock);
    drive(id, 1'b1, wide, sub, a, b);
    @(negedge clock);
    chk("busy_rise", 64'(bus.busy), 64'd1);
    drive(id, 1'b1, ~wide, ~sub, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clock);
      cyc++;
      got = done_of(id);
    end
    res = bus.result;
    co  = bus.cout;
    ov  = bus.ovf;
    chk("latency",    64'(cyc),              wide ? 64'd3 : 64'd2);
    chk("result",     bus.result,            e[63:0]);
    chk("cout",       64'(bus.cout),         64'(e[64]));
    chk("ovf",        64'(bus.ovf),          64'(e[65]));
    chk("other_done", 64'(done_of(1 - id)), 64'd0);
    chk("busy_fall",  64'(bus.busy),         64'd0);
    @(negedge clock);
    chk("done_width", 64'(done_of(id)),      64'd0);
    chk("no_regrant", 64'(bus.busy),         64'd0);
    chk("hold",       bus.result,            e[63:0]);
    drive(id, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  // Requester that keeps req high across back-to-back ops, dropping it after the last.
  task automatic requester(input int id, input int n);
    logic        w;
    logic        s;
    logic [63:0] a;
    logic [63:0] b;
    logic [65:0] e;
    int          cyc;
    bit          got;
    w = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    a = rnd_opnd();
    b = rnd_opnd();
    drive(id, 1'b1, w, s, a, b);
    for (int k = 0; k < n; k++) begin
      e   = ref_op(w, s, a, b);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
        @(negedge clock);
        cyc++;
        got = done_of(id);
      end
      chk("cont_done_seen", 64'(got),      64'd1);
      chk("cont_result",    bus.result,    e[63:0]);
      chk("cont_cout",      64'(bus.cout), 64'(e[64]));
      chk("cont_ovf",       64'(bus.ovf),  64'(e[65]));
      if (k < n - 1) begin
        w = 1'($urandom_range(0, 1));
        s = 1'($urandom_range(0, 1));
        a = rnd_opnd();
        b = rnd_opnd();
        drive(id, 1'b1, w, s, a, b);
      end else begin
        @(negedge clock);
        drive(id, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("dual_done", 64'(bus.done0 & bus.done1), 64'd0);
      if (bus.done0) done_order.push_back(0);
      if (bus.done1) done_order.push_back(1);
    end
  end

  initial begin
    logic [63:0] res;
    logic        co;
    logic        ov;
    logic        w;
    logic        s;
    int          id;
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clock);
    chk("rst_result", bus.result,      64'd0);
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_done",   64'({bus.done0, bus.done1, bus.cout, bus.ovf}), 64'd0);
    chk("rst_cla",    64'({bus.cla_a, bus.cla_b}), 64'd0);
    chk("rst_c0",     64'(bus.cla_c0), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_busy",  64'(bus.busy),   64'd0);

    run_op(0, 1'b0, 1'b0, 64'd5, 64'd3, res, co, ov);
    chk("add32_res", res, 64'h0000_0000_0000_0008);
    chk("add32_flags", 64'({co, ov}), 64'd0);

    run_op(1, 1'b0, 1'b1, 64'd5, 64'd7, res, co, ov);
    chk("sub32_res", res, 64'h0000_0000_FFFF_FFFE);
    chk("sub32_flags", 64'({co, ov}), 64'd0);

    run_op(0, 1'b0, 1'b0, 64'h7FFF_FFFF, 64'd1, res, co, ov);
    chk("ovf32_res", res, 64'h0000_0000_8000_0000);
    chk("ovf32_flags", 64'({co, ov}), 64'b01);

    run_op(1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, res, co, ov);
    chk("add64_res", res, 64'h0000_0001_0000_0000);

    run_op(0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, co, ov);
    chk("add64_ff_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add64_ff_flags", 64'({co, ov}), 64'b10);

    for (int i = 0; i < 30; i++) begin
      id = $urandom_range(0, 1);
      w  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      run_op(id, w, s, rnd_opnd(), rnd_opnd(), res, co, ov);
    end

    // Abort a 64-bit op in its high pass.
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111);
    @(negedge clock);
    @(negedge clock);
    chk("hi_busy", 64'(bus.busy), 64'd1);
    chk("hi_cla_a", 64'(bus.cla_a), 64'h1234_5678);
    reset_n = 1'b0;
    #1;
    chk("abort_busy",   64'(bus.busy),   64'd0);
    chk("abort_result", bus.result,      64'd0);
    chk("abort_done",   64'(bus.done0),  64'd0);
    chk("abort_cla",    64'(bus.cla_a),  64'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clock);
    chk("abort_nodone", 64'({bus.done0, bus.done1}), 64'd0);
    reset_n = 1'b1;

    // Contention from reset: expect strict alternation starting with requester 0.
    @(negedge clock);
    mon_en = 1'b1;
    fork
      requester(0, 6);
      requester(1, 6);
    join
    repeat (2) @(negedge clock);
    mon_en = 1'b0;
    chk("order_len", 64'(done_order.size()), 64'd12);
    for (int i = 0; i < done_order.size(); i++)
      chk($sformatf("order_%0d", i), 64'(done_order[i]), 64'(i % 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
